// File: rtl/tcbm_device_link_if.sv
// Signal bundle for the TCBM device link: connector pins plus the rx/tx byte streams to the drive core.
// The slave modport is the device-side responder; master is the host/core side driving it.
interface tcbm_device_link_if;
    logic [7:0] tcbm_data_i;
    logic [7:0] tcbm_data_o;
    logic       tcbm_data_oe;
    logic [1:0] tcbm_status;
    logic       tcbm_dav;
    logic       tcbm_ack;
    logic [7:0] rx_data;
    logic       rx_atn;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_eoi;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] status_in;
    logic       err_proto;
    logic       err_timeout;

    modport slave (
        input  tcbm_data_i, tcbm_dav, rx_ready, tx_data, tx_eoi, tx_valid, status_in,
        output tcbm_data_o, tcbm_data_oe, tcbm_status, tcbm_ack,
               rx_data, rx_atn, rx_valid, tx_ready, err_proto, err_timeout
    );

    modport master (
        output tcbm_data_i, tcbm_dav, rx_ready, tx_data, tx_eoi, tx_valid, status_in,
        input  tcbm_data_o, tcbm_data_oe, tcbm_status, tcbm_ack,
               rx_data, rx_atn, rx_valid, tx_ready, err_proto, err_timeout
    );
endinterface

// File: rtl/tcbm_device_link.sv
// Drive-side TCBM responder: decodes command/data handshakes from the host's 6523 ports
// and bridges host writes/reads to the drive core's rx/tx byte streams.
module tcbm_device_link #(
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 50000
) (
    input logic clk,
    input logic reset,
    tcbm_device_link_if.slave link
);

    localparam logic [7:0]  CMD_ATN   = 8'h81;
    localparam logic [7:0]  CMD_WR    = 8'h83;
    localparam logic [7:0]  CMD_RD    = 8'h84;
    localparam logic [15:0] TOUT_LIM  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  SETUP_LIM = 8'(SETUP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CMD_ACK, WAIT_DATA, RX_HOLD, TX_WAIT, WAIT_REL, REL_ACK, DUMMY_ACK
    } state_t;

    state_t state, last_state;

    logic [SYNC_STAGES-1:0] dav_sr;
    logic [7:0]             data_sr [SYNC_STAGES];
    logic                   dav_s, dav_prev;
    logic [7:0]             data_s;
    logic [7:0]             cmd, hold_data;
    logic                   hold_atn, loaded;
    logic [15:0]            tcnt;
    logic [7:0]             setup_cnt;
    logic                   cmd_known, timed, abort_now;

    assign dav_s  = dav_sr[SYNC_STAGES-1];
    assign data_s = data_sr[SYNC_STAGES-1];

    assign cmd_known = (cmd == CMD_ATN) || (cmd == CMD_WR) || (cmd == CMD_RD);
    assign timed     = (state != IDLE) && (state != REL_ACK);
    assign abort_now = timed && ((tcnt == TOUT_LIM) ||
                       (dav_s && ((state == RX_HOLD) || (state == TX_WAIT))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dav_sr   <= '1;
            dav_prev <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
        end else begin
            dav_sr     <= {dav_sr[SYNC_STAGES-2:0], link.tcbm_dav};
            dav_prev   <= dav_s;
            data_sr[0] <= link.tcbm_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
        end
    end

    // Timeout counter restarts whenever the FSM has just moved to a new state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_state <= IDLE;
            tcnt       <= '0;
        end else begin
            last_state <= state;
            if (state != last_state) tcnt <= '0;
            else if (tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            link.tcbm_ack    <= 1'b1;
            link.tcbm_data_oe <= 1'b0;
            link.tcbm_data_o <= '0;
            link.tcbm_status <= '0;
            link.rx_data     <= '0;
            link.rx_atn      <= 1'b0;
            link.rx_valid    <= 1'b0;
            link.tx_ready    <= 1'b0;
            link.err_proto   <= 1'b0;
            link.err_timeout <= 1'b0;
            cmd              <= '0;
            hold_data        <= '0;
            hold_atn         <= 1'b0;
            loaded           <= 1'b0;
            setup_cnt        <= '0;
        end else begin
            link.tx_ready    <= 1'b0;
            link.err_proto   <= 1'b0;
            link.err_timeout <= 1'b0;
            if (link.rx_valid && link.rx_ready) link.rx_valid <= 1'b0;

            if (abort_now) begin
                link.tcbm_ack     <= 1'b1;
                link.tcbm_data_oe <= 1'b0;
                link.tcbm_status  <= '0;
                link.err_timeout  <= 1'b1;
                loaded            <= 1'b0;
                state             <= IDLE;
            end else begin
                case (state)
                    // Only a fresh DAV falling edge starts a command, so a host still
                    // holding DAV low after an abort cannot replay a stale byte.
                    IDLE: if (!dav_s && dav_prev) begin
                        cmd           <= data_s;
                        link.tcbm_ack <= 1'b0;
                        state         <= CMD_ACK;
                    end
                    CMD_ACK: if (dav_s) begin
                        link.tcbm_ack  <= 1'b1;
                        link.err_proto <= !cmd_known;
                        state          <= WAIT_DATA;
                    end
                    WAIT_DATA: if (!dav_s) begin
                        loaded <= 1'b0;
                        if ((cmd == CMD_ATN) || (cmd == CMD_WR)) begin
                            hold_data <= data_s;
                            hold_atn  <= (cmd == CMD_ATN);
                            state     <= RX_HOLD;
                        end else if (cmd == CMD_RD) begin
                            state <= TX_WAIT;
                        end else begin
                            link.tcbm_ack <= 1'b0;
                            state         <= DUMMY_ACK;
                        end
                    end
                    RX_HOLD: begin
                        if (!loaded) begin
                            if (!link.rx_valid || link.rx_ready) begin
                                link.rx_data     <= hold_data;
                                link.rx_atn      <= hold_atn;
                                link.rx_valid    <= 1'b1;
                                link.tcbm_status <= link.status_in;
                                loaded           <= 1'b1;
                                setup_cnt        <= '0;
                            end
                        end else if (setup_cnt == SETUP_LIM) begin
                            link.tcbm_ack <= 1'b0;
                            loaded        <= 1'b0;
                            state         <= WAIT_REL;
                        end else begin
                            setup_cnt <= setup_cnt + 8'd1;
                        end
                    end
                    TX_WAIT: begin
                        if (!loaded) begin
                            if (link.tx_valid) begin
                                link.tcbm_data_o  <= link.tx_data;
                                link.tcbm_data_oe <= 1'b1;
                                link.tcbm_status  <= link.tx_eoi ? 2'b11 : 2'b00;
                                link.tx_ready     <= 1'b1;
                                loaded            <= 1'b1;
                                setup_cnt         <= '0;
                            end
                        end else if (setup_cnt == SETUP_LIM) begin
                            link.tcbm_ack <= 1'b0;
                            loaded        <= 1'b0;
                            state         <= WAIT_REL;
                        end else begin
                            setup_cnt <= setup_cnt + 8'd1;
                        end
                    end
                    // Bus is released one cycle before ACK rises so the host never sees both driven.
                    WAIT_REL: if (dav_s) begin
                        link.tcbm_data_oe <= 1'b0;
                        state             <= REL_ACK;
                    end
                    REL_ACK: begin
                        link.tcbm_ack    <= 1'b1;
                        link.tcbm_status <= '0;
                        state            <= IDLE;
                    end
                    DUMMY_ACK: if (dav_s) begin
                        link.tcbm_ack <= 1'b1;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcbm_device_link.sv
// Directed bench for tcbm_device_link: plays the host side of the TCBM handshake and the core
// side of the rx/tx streams, comparing against hand-computed expectations.
module tb_tcbm_device_link;

    localparam int SYNC_STAGES  = 2;
    localparam int SETUP_CYCLES = 2;
    localparam int TIMEOUT      = 200;
    localparam int HS_LIMIT     = 60;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    tcbm_device_link_if link ();

    tcbm_device_link #(
        .SYNC_STAGES (SYNC_STAGES),
        .SETUP_CYCLES(SETUP_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .link (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] rxQ[$];
    int         txReadyCnt = 0;
    int         errProtoCnt = 0;
    int         errTimeoutCnt = 0;
    int         rxValidCycles = 0;
    int         stableCnt = 0;
    int         ackFallStable = 0;
    logic [1:0] ackFallStatus = '0;
    logic       ackFallOe = 1'b0;
    logic       ackRisePrevOe = 1'b0;
    logic       prevAck = 1'b1;
    logic       prevOe = 1'b0;
    logic [10:0] prevBus = '0;
    logic [10:0] busNow;

    // Negedge monitor: scoreboard of delivered rx bytes, pulse counters, and bus stability around ACK edges.
    always @(negedge clk) begin
        if (link.rx_valid && link.rx_ready) rxQ.push_back({link.rx_atn, link.rx_data});
        if (link.rx_valid)    rxValidCycles = rxValidCycles + 1;
        if (link.tx_ready)    txReadyCnt    = txReadyCnt + 1;
        if (link.err_proto)   errProtoCnt   = errProtoCnt + 1;
        if (link.err_timeout) errTimeoutCnt = errTimeoutCnt + 1;
        busNow = {link.tcbm_data_oe, link.tcbm_data_o, link.tcbm_status};
        if (prevAck && !link.tcbm_ack) begin
            ackFallStable = stableCnt;
            ackFallStatus = link.tcbm_status;
            ackFallOe     = link.tcbm_data_oe;
        end
        if (!prevAck && link.tcbm_ack) ackRisePrevOe = prevOe;
        if (link.tcbm_ack) stableCnt = (busNow == prevBus) ? stableCnt + 1 : 1;
        else               stableCnt = 0;
        prevBus = busNow;
        prevAck = link.tcbm_ack;
        prevOe  = link.tcbm_data_oe;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full host phase: present a byte, pull DAV low, wait ACK low, release DAV, wait ACK high.
    task automatic applyStimulus(input logic [7:0] value, output logic [7:0] readBack);
        int n;
        link.tcbm_data_i = value;
        tick();
        link.tcbm_dav = 1'b0;
        n = 0;
        while (link.tcbm_ack && n < HS_LIMIT) begin tick(); n++; end
        checkOutput("ack_falls", {31'd0, link.tcbm_ack}, 32'd0);
        readBack = link.tcbm_data_o;
        link.tcbm_dav = 1'b1;
        n = 0;
        while (!link.tcbm_ack && n < HS_LIMIT) begin tick(); n++; end
        checkOutput("ack_rises", {31'd0, link.tcbm_ack}, 32'd1);
    endtask

    logic [7:0] rb;
    int         base, baseTx, baseProto, baseTout, baseRxv, n, zeroAck;

    initial begin
        reset = 1'b1;
        link.tcbm_data_i = 8'h00;
        link.tcbm_dav    = 1'b1;
        link.rx_ready    = 1'b1;
        link.tx_data     = 8'h00;
        link.tx_eoi      = 1'b0;
        link.tx_valid    = 1'b0;
        link.status_in   = 2'b00;
        repeat (3) tick();
        checkOutput("rst_ack",    {31'd0, link.tcbm_ack}, 32'd1);
        checkOutput("rst_oe",     {31'd0, link.tcbm_data_oe}, 32'd0);
        checkOutput("rst_data_o", {24'd0, link.tcbm_data_o}, 32'd0);
        checkOutput("rst_status", {30'd0, link.tcbm_status}, 32'd0);
        checkOutput("rst_rx_valid", {31'd0, link.rx_valid}, 32'd0);
        checkOutput("rst_pulses", {29'd0, link.tx_ready, link.err_proto, link.err_timeout}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Host write $83/$5A with status_in=01
        link.status_in = 2'b01;
        base = rxQ.size(); baseRxv = rxValidCycles;
        applyStimulus(8'h83, rb);
        applyStimulus(8'h5A, rb);
        repeat (3) tick();
        checkOutput("wr_count", rxQ.size() - base, 32'd1);
        if (rxQ.size() > base) checkOutput("wr_byte", {23'd0, rxQ[base]}, 32'h05A);
        checkOutput("wr_valid_cycles", rxValidCycles - baseRxv, 32'd1);
        checkOutput("wr_status_ack_low", {30'd0, ackFallStatus}, 32'd1);
        checkOutput("wr_setup", {31'd0, ackFallStable >= SETUP_CYCLES}, 32'd1);
        checkOutput("wr_status_idle", {30'd0, link.tcbm_status}, 32'd0);
        checkOutput("wr_ack_idle", {31'd0, link.tcbm_ack}, 32'd1);

        // LISTEN 8 under ATN
        base = rxQ.size();
        applyStimulus(8'h81, rb);
        applyStimulus(8'h28, rb);
        repeat (3) tick();
        checkOutput("atn_count", rxQ.size() - base, 32'd1);
        if (rxQ.size() > base) checkOutput("atn_byte", {23'd0, rxQ[base]}, 32'h128);

        // Back-pressure: F0 parked in rx, second byte must stall with ACK high
        link.rx_ready = 1'b0;
        base = rxQ.size();
        applyStimulus(8'h81, rb);
        applyStimulus(8'hF0, rb);
        applyStimulus(8'h83, rb);
        link.tcbm_data_i = 8'h11;
        tick();
        link.tcbm_dav = 1'b0;
        zeroAck = 0;
        repeat (20) begin tick(); if (!link.tcbm_ack) zeroAck++; end
        checkOutput("stall_ack_high", zeroAck, 32'd0);
        checkOutput("stall_rx_hold", {22'd0, link.rx_valid, link.rx_atn, link.rx_data}, 32'h3F0);
        link.rx_ready = 1'b1;
        n = 0;
        while (link.tcbm_ack && n < HS_LIMIT) begin tick(); n++; end
        checkOutput("stall_ack_falls", {31'd0, link.tcbm_ack}, 32'd0);
        link.tcbm_dav = 1'b1;
        n = 0;
        while (!link.tcbm_ack && n < HS_LIMIT) begin tick(); n++; end
        checkOutput("stall_ack_rises", {31'd0, link.tcbm_ack}, 32'd1);
        repeat (3) tick();
        checkOutput("stall_count", rxQ.size() - base, 32'd2);
        if (rxQ.size() >= base + 2) begin
            checkOutput("stall_first", {23'd0, rxQ[base]}, 32'h1F0);
            checkOutput("stall_second", {23'd0, rxQ[base+1]}, 32'h011);
        end

        // Host read $84 with last byte A5
        link.tx_valid = 1'b1; link.tx_data = 8'hA5; link.tx_eoi = 1'b1;
        baseTx = txReadyCnt;
        applyStimulus(8'h84, rb);
        applyStimulus(8'h00, rb);
        link.tx_valid = 1'b0;
        repeat (2) tick();
        checkOutput("rd_data", {24'd0, rb}, 32'hA5);
        checkOutput("rd_oe_ack_low", {31'd0, ackFallOe}, 32'd1);
        checkOutput("rd_status_eoi", {30'd0, ackFallStatus}, 32'd3);
        checkOutput("rd_setup", {31'd0, ackFallStable >= SETUP_CYCLES}, 32'd1);
        checkOutput("rd_tx_ready", txReadyCnt - baseTx, 32'd1);
        checkOutput("rd_oe_before_ack", {31'd0, ackRisePrevOe}, 32'd0);
        checkOutput("rd_oe_idle", {31'd0, link.tcbm_data_oe}, 32'd0);

        // Read with nothing offered: timeout abort
        baseTout = errTimeoutCnt;
        applyStimulus(8'h84, rb);
        link.tcbm_data_i = 8'h00;
        tick();
        link.tcbm_dav = 1'b0;
        n = 0;
        while (!link.err_timeout && n < TIMEOUT + 100) begin tick(); n++; end
        checkOutput("tout_seen", {31'd0, link.err_timeout}, 32'd1);
        checkOutput("tout_latency", {31'd0, (n >= TIMEOUT) && (n <= TIMEOUT + 10)}, 32'd1);
        checkOutput("tout_bus", {29'd0, link.tcbm_ack, link.tcbm_data_oe, link.tcbm_status == 2'b00}, 32'd5);
        link.tcbm_dav = 1'b1;
        repeat (5) tick();
        checkOutput("tout_pulses", errTimeoutCnt - baseTout, 32'd1);
        base = rxQ.size();
        applyStimulus(8'h83, rb);
        applyStimulus(8'h01, rb);
        repeat (3) tick();
        checkOutput("tout_recover", rxQ.size() - base, 32'd1);
        if (rxQ.size() > base) checkOutput("tout_recover_byte", {23'd0, rxQ[base]}, 32'h001);

        // Unknown command $99
        base = rxQ.size(); baseTx = txReadyCnt; baseProto = errProtoCnt;
        applyStimulus(8'h99, rb);
        applyStimulus(8'h77, rb);
        repeat (3) tick();
        checkOutput("proto_pulse", errProtoCnt - baseProto, 32'd1);
        checkOutput("proto_no_rx", rxQ.size() - base, 32'd0);
        checkOutput("proto_no_tx", txReadyCnt - baseTx, 32'd0);

        // Reset while driving the bus in TX_WAIT
        link.tx_valid = 1'b1; link.tx_data = 8'h3C; link.tx_eoi = 1'b0;
        applyStimulus(8'h84, rb);
        link.tcbm_data_i = 8'h00;
        tick();
        link.tcbm_dav = 1'b0;
        n = 0;
        while (!link.tcbm_data_oe && n < HS_LIMIT) begin tick(); n++; end
        checkOutput("rst_mid_oe_on", {31'd0, link.tcbm_data_oe}, 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_mid_oe_off", {31'd0, link.tcbm_data_oe}, 32'd0);
        checkOutput("rst_mid_ack_high", {31'd0, link.tcbm_ack}, 32'd1);
        link.tx_valid = 1'b0;
        link.tcbm_dav = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("rst_mid_idle", {30'd0, link.tcbm_ack, link.tcbm_data_oe}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
